// File: rtl/div_pkg.sv
// Shared types and the remainder consistency check for the divider result buffer.
package div_pkg;

    localparam int DIV_QW = 3;
    localparam int DIV_DW = 2;
    localparam int DIV_RW = 8;

    typedef struct packed {
        logic [DIV_QW-1:0] q;
        logic [DIV_DW-1:0] rem;
        logic              dbz;
        logic              err;
    } div_result_t;

    // A remainder is consistent only if the upper rout bits are clear and rem < divisor.
    function automatic logic [1:0] rem_check(input logic [DIV_RW-1:0] rout,
                                             input logic [DIV_DW-1:0] dv);
        logic dbz;
        logic err;
        dbz = (dv == '0);
        err = !dbz && ((rout[DIV_RW-1:DIV_DW] != '0) || (rout[DIV_DW-1:0] >= dv));
        return {dbz, err};
    endfunction

endpackage

// File: rtl/div_fifo2.sv
// Two-entry circular valid/ready FIFO; ready depends only on the registered count.
module div_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_valid,
    output logic         o_push_ready,
    input  logic [W-1:0] i_push_data,
    output logic         o_pop_valid,
    input  logic         i_pop_ready,
    output logic [W-1:0] o_pop_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_push_ready = (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;
    assign o_pop_data   = o_pop_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/div_result_buffer.sv
// Captures divider results, flags divide-by-zero / bad remainder, buffers them and counts deliveries.
module div_result_buffer
    import div_pkg::*;
#(
    parameter int QW = DIV_QW,
    parameter int DW = DIV_DW,
    parameter int RW = DIV_RW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_q,
    input  logic [RW-1:0] in_rout,
    input  logic [DW-1:0] in_div,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic [DW-1:0] out_rem,
    output logic          out_dbz,
    output logic          out_err,
    output logic [CW-1:0] cnt_done,
    output logic [CW-1:0] cnt_err
);

    div_result_t   w_entry;
    div_result_t   w_head;
    logic [1:0]    w_flags;
    logic          w_pop;
    logic [CW-1:0] r_cnt_done;
    logic [CW-1:0] r_cnt_err;

    always_comb begin
        w_flags       = rem_check(in_rout, in_div);
        w_entry.q     = in_q;
        w_entry.rem   = in_rout[DW-1:0];
        w_entry.dbz   = w_flags[1];
        w_entry.err   = w_flags[0];
    end

    div_fifo2 #(
        .W($bits(div_result_t))
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  (w_entry),
        .o_pop_valid  (out_valid),
        .i_pop_ready  (out_ready),
        .o_pop_data   (w_head)
    );

    assign out_q   = w_head.q;
    assign out_rem = w_head.rem;
    assign out_dbz = w_head.dbz;
    assign out_err = w_head.err;
    assign w_pop   = out_valid && out_ready;

    // Debug counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_done <= '0;
            r_cnt_err  <= '0;
        end else if (w_pop) begin
            if (r_cnt_done != '1) begin
                r_cnt_done <= r_cnt_done + 1'b1;
            end
            if ((w_head.err || w_head.dbz) && (r_cnt_err != '1)) begin
                r_cnt_err <= r_cnt_err + 1'b1;
            end
        end
    end

    assign cnt_done = r_cnt_done;
    assign cnt_err  = r_cnt_err;

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer: vector table, hand sequences and a queue-based random model.
module tb_div_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_q;
    logic [7:0]  in_rout;
    logic [1:0]  in_div;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_q;
    logic [1:0]  out_rem;
    logic        out_dbz;
    logic        out_err;
    logic [15:0] cnt_done;
    logic [15:0] cnt_err;

    always #5 clk = ~clk;

    div_result_buffer #(.QW(3), .DW(2), .RW(8), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_rout   (in_rout),
        .in_div    (in_div),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_rem   (out_rem),
        .out_dbz   (out_dbz),
        .out_err   (out_err),
        .cnt_done  (cnt_done),
        .cnt_err   (cnt_err)
    );

    typedef struct {
        logic [2:0] q;
        logic [7:0] rout;
        logic [1:0] dv;
        logic [2:0] eq;
        logic [1:0] erem;
        logic       edbz;
        logic       eerr;
    } vec_t;

    typedef struct {
        int q;
        int rem;
        int dbz;
        int err;
    } ent_t;

    vec_t vecs[7];
    ent_t mq[$];
    int   m_done;
    int   m_err;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a remainder is consistent exactly when rout < divisor.
    function automatic ent_t make_ent(input int q, input int rout, input int dv);
        ent_t e;
        e.q   = q;
        e.rem = rout % 4;
        e.dbz = (dv == 0) ? 1 : 0;
        e.err = (dv != 0 && rout >= dv) ? 1 : 0;
        return e;
    endfunction

    task automatic drive_cycle(input bit v, input bit r, input int q, input int rout, input int dv);
        bit   do_push;
        bit   do_pop;
        ent_t h;
        in_valid  = v;
        out_ready = r;
        in_q      = q[2:0];
        in_rout   = rout[7:0];
        in_div    = dv[1:0];
        h = '{0, 0, 0, 0};
        if (mq.size() != 0) h = mq[0];
        chk("in_ready", {31'd0, in_ready}, (mq.size() != 2) ? 1 : 0);
        chk("out_valid", {31'd0, out_valid}, (mq.size() != 0) ? 1 : 0);
        chk("out_q", {29'd0, out_q}, h.q);
        chk("out_rem", {30'd0, out_rem}, h.rem);
        chk("out_dbz", {31'd0, out_dbz}, h.dbz);
        chk("out_err", {31'd0, out_err}, h.err);
        chk("cnt_done", {16'd0, cnt_done}, m_done);
        chk("cnt_err", {16'd0, cnt_err}, m_err);
        do_push = v && (mq.size() != 2);
        do_pop  = r && (mq.size() != 0);
        step();
        if (do_pop) begin
            h = mq.pop_front();
            if (m_done < 65535) m_done++;
            if ((h.err != 0 || h.dbz != 0) && m_err < 65535) m_err++;
        end
        if (do_push) mq.push_back(make_ent(q, rout, dv));
    endtask

    initial begin
        int start_done;
        checks = 0;
        errors = 0;
        m_done = 0;
        m_err  = 0;
        vecs[0] = '{3'd2, 8'h01, 2'd2, 3'd2, 2'd1, 1'b0, 1'b0};
        vecs[1] = '{3'd7, 8'h04, 2'd0, 3'd7, 2'd0, 1'b1, 1'b0};
        vecs[2] = '{3'd1, 8'h05, 2'd2, 3'd1, 2'd1, 1'b0, 1'b1};
        vecs[3] = '{3'd0, 8'h02, 2'd2, 3'd0, 2'd2, 1'b0, 1'b1};
        vecs[4] = '{3'd5, 8'h03, 2'd3, 3'd5, 2'd3, 1'b0, 1'b1};
        vecs[5] = '{3'd4, 8'h02, 2'd3, 3'd4, 2'd2, 1'b0, 1'b0};
        vecs[6] = '{3'd3, 8'h80, 2'd1, 3'd3, 2'd0, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_q = '0; in_rout = '0; in_div = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_q", {29'd0, out_q}, 0);
        chk("rst_out_rem", {30'd0, out_rem}, 0);
        chk("rst_out_dbz", {31'd0, out_dbz}, 0);
        chk("rst_out_err", {31'd0, out_err}, 0);
        chk("rst_cnt_done", {16'd0, cnt_done}, 0);
        chk("rst_cnt_err", {16'd0, cnt_err}, 0);

        // Vector table: push alone, check the head against the table, then pop.
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1, 0, vecs[i].q, vecs[i].rout, vecs[i].dv);
            chk("vec_valid", {31'd0, out_valid}, 1);
            chk("vec_q", {29'd0, out_q}, {29'd0, vecs[i].eq});
            chk("vec_rem", {30'd0, out_rem}, {30'd0, vecs[i].erem});
            chk("vec_dbz", {31'd0, out_dbz}, {31'd0, vecs[i].edbz});
            chk("vec_err", {31'd0, out_err}, {31'd0, vecs[i].eerr});
            drive_cycle(0, 1, 0, 0, 1);
            chk("vec_empty", {31'd0, out_valid}, 0);
        end
        chk("vec_cnt_done", {16'd0, cnt_done}, 7);
        chk("vec_cnt_err", {16'd0, cnt_err}, 5);

        // Backpressure: fill, hold the third value, then drain in order.
        drive_cycle(1, 0, 1, 0, 1);
        drive_cycle(1, 0, 2, 0, 1);
        chk("bp_full_ready", {31'd0, in_ready}, 0);
        chk("bp_head_hold", {29'd0, out_q}, 1);
        drive_cycle(1, 0, 3, 0, 1);
        chk("bp_still_full", {31'd0, in_ready}, 0);
        chk("bp_head_stable", {29'd0, out_q}, 1);
        drive_cycle(1, 1, 3, 0, 1);
        chk("bp_second", {29'd0, out_q}, 2);
        chk("bp_ready_back", {31'd0, in_ready}, 1);
        drive_cycle(1, 1, 3, 0, 1);
        chk("bp_third", {29'd0, out_q}, 3);
        drive_cycle(0, 1, 0, 0, 1);
        chk("bp_drained", {31'd0, out_valid}, 0);
        chk("bp_cnt_done", {16'd0, cnt_done}, 10);

        // Streaming with push and pop every cycle.
        start_done = m_done;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 1, i % 8, 0, 1);
            chk("stream_ready", {31'd0, in_ready}, 1);
        end
        drive_cycle(0, 1, 0, 0, 1);
        chk("stream_cnt_done", {16'd0, cnt_done}, start_done + 10);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 7), $urandom_range(0, 255) & ($urandom_range(0, 1) ? 8'h03 : 8'hFF),
                        $urandom_range(0, 3));
        end

        // Reset with two entries buffered.
        drive_cycle(0, 0, 0, 0, 1);
        while (mq.size() < 2) drive_cycle(1, 0, 5, 9, 2);
        chk("pre_rst_full", {31'd0, in_ready}, 0);
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        mq.delete();
        m_done = 0;
        m_err  = 0;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_done", {16'd0, cnt_done}, 0);
        chk("mid_rst_err", {16'd0, cnt_err}, 0);
        drive_cycle(0, 1, 0, 0, 1);

        // Saturation: well over 65535 pops.
        in_valid = 1'b1; out_ready = 1'b1; in_q = 3'd1; in_rout = 8'h00; in_div = 2'd1;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        step();
        chk("sat_done", {16'd0, cnt_done}, 32'hFFFF);
        chk("sat_err", {16'd0, cnt_err}, 0);
        chk("sat_empty", {31'd0, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Downstream stage of the combinational restoring divider array.
- Captures the quotient, the remainder vector and the divisor used, once per valid cycle.
- Checks the remainder for consistency, flags divide-by-zero, and buffers results in a 2-entry FIFO with valid/ready flow control toward the consumer.
- Keeps saturating completion and error counters for debug.

Parameters:
QW, 3, quotient width (matches divider q)
DW, 2, divisor width; the true remainder occupies rout[DW-1:0]
RW, 8, divider remainder-vector width (rout)
CW, 16, counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  divider result valid
in_ready  output  1  buffer can accept
in_q  input  QW  divider quotient
in_rout  input  RW  divider remainder vector
in_div  input  DW  divisor that produced this result
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_q  output  QW  buffered quotient
out_rem  output  DW  buffered remainder, rout[DW-1:0]
out_dbz  output  1  divisor was zero
out_err  output  1  remainder inconsistent
cnt_done  output  CW  results delivered
cnt_err  output  CW  delivered results with out_err or out_dbz

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values:
  - FIFO count = 0, so out_valid = 0 and in_ready = 1.
  - out_q, out_rem, out_dbz, out_err = 0.
  - cnt_done, cnt_err = 0.
- Reset asserted mid-operation discards all buffered entries on that edge.
- Entry formation, at push:
  - q = in_q; rem = in_rout[DW-1:0].
  - dbz = (in_div == 0).
  - err = !dbz && (in_rout[RW-1:DW] != 0 || in_rout[DW-1:0] >= in_div).
  - When dbz = 1, err = 0 and q/rem are stored unmodified.
- Storage: 2-entry circular FIFO with 1-bit read and write pointers and a 2-bit count.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != 2), decoded combinationally from registered count. No dependence on out_ready, so there is no comb path from out_ready to in_ready.
- out_valid = (count != 0). Outputs always show the head entry; zeros when empty.
- Latency: a push into an empty FIFO makes out_valid = 1 on the next cycle. There is no bypass.
- Boundary conditions:
  - Push and pop in the same cycle with count = 1: count stays 1 and both pointers advance.
  - Count = 2: in_ready = 0, so no push is possible; a pop frees a slot from the next cycle.
  - Count = 0: a pop is impossible because out_valid = 0.
  - Pointers wrap modulo 2.
- in_valid while in_ready = 0: data is ignored; the upstream must hold it.
- Counters update on pop only:
  - cnt_done += 1.
  - cnt_err += 1 when the popped entry has err or dbz.
  - Both saturate at all-ones and do not wrap.
- Head outputs must remain stable while out_valid && !out_ready.

Decomposition:
- Shared package div_pkg holds:
  - constants QW, DW, RW defaults;
  - packed typedef div_result_t {q, rem, dbz, err};
  - function rem_check(rout, div) returning {dbz, err}.
- One sub-module: div_fifo2 (generic 2-entry valid/ready FIFO over div_result_t).
- Counters and entry formation stay in the top level.

Test Plan:
1. Normal result (rin=5, div=2): in_q=3'b010, in_rout=8'h01, in_div=2'b10, out_ready=1.
   -> next cycle out_valid=1, out_q=2, out_rem=1, out_dbz=0, out_err=0; then cnt_done=1, cnt_err=0.
2. Divide by zero: in_div=0, in_q=3'b111, in_rout=8'h04.
   -> out_dbz=1, out_err=0, out_q=7, out_rem=0; cnt_err increments on pop.
3. Bad remainder:
   - in_rout=8'h05 with in_div=2 -> out_err=1, out_rem=1.
   - in_rout=8'h02 with in_div=2 -> out_err=1.
4. Backpressure: out_ready=0, three consecutive in_valid cycles with q=1,2,3.
   - in_ready drops after 2 accepts; out_q holds 1.
   - Raise out_ready -> outputs q=1 then q=2; the third value is accepted once in_ready returns; order is preserved.
5. Simultaneous push/pop at count=1, streaming 10 results with in_valid=out_ready=1 every cycle.
   -> throughput 1/cycle, in_ready stays 1, cnt_done=10.
6. Reset mid-operation and saturation:
   - rst_n=0 for one edge with 2 entries buffered -> out_valid=0, in_ready=1, counters 0.
   - Force 65536 pops with CW=16 -> cnt_done stays 16'hFFFF.
